io_interrupt_controller: RTL and testbench
==========================================

IO_INTERRUPT_CONTROLLER -- requirements
Module: io_interrupt_controller

Interface
REQ-001 Parameter NUM_SOURCES, default 16: number of interrupt sources; legal values are 1..32.
REQ-002 Parameter BASE_ADDRESS, default 'h100: IO byte address of the first register.
REQ-003 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the block is in reset while reset is low.
REQ-005 interrupt_sources  input  NUM_SOURCES  asynchronous device interrupt lines, one bit per source.
REQ-006 io_write_en  input  1  IO write strobe from the processor, valid for one cycle.
REQ-007 io_read_en  input  1  IO read strobe from the processor, valid for one cycle.
REQ-008 io_address  input  32 (scalar_t)  IO byte address.
REQ-009 io_write_data  input  32 (scalar_t)  IO write data.
REQ-010 io_read_data  output  32 (scalar_t)  registered read data.
REQ-011 io_read_hit  output  1  registered flag: io_read_data belongs to this block.
REQ-012 interrupt_req  output  1  registered interrupt request to the processor top-level interrupt_req input.

Function
REQ-013 Register map, word offsets from BASE_ADDRESS: 'h0 PENDING (R, W1C); 'h4 MASK (R/W, 1 = enabled); 'h8 MODE (R/W, 1 = edge, 0 = level); 'hC ACTIVE (R only); 'h10 SET (W only, write-1-to-set).
REQ-014 Any address outside BASE_ADDRESS..BASE_ADDRESS+'h10, or with io_address[1:0] != 0, is ignored for both writes and reads.
REQ-015 Each source passes through a two-flop synchronizer; a transition sampled at cycle N appears at the synchronizer output at cycle N+2.
REQ-016 Edge mode: a 0->1 transition of the synchronized line sets the PENDING bit at cycle N+3.
REQ-017 Level mode: the PENDING bit equals the synchronized level, registered, so it appears at cycle N+3.
REQ-018 W1C of PENDING clears the written bits of edge-mode sources only; level-mode bits are unaffected.
REQ-019 Writing the SET register sets the written PENDING bits of edge-mode sources on the next cycle.
REQ-020 Set priority: a set event (edge or SET write) and a W1C on the same bit in the same cycle leave the bit set.
REQ-021 MASK does not gate capture; pending state is recorded regardless of MASK.
REQ-022 interrupt_req is a register equal to |(PENDING & MASK) of the previous cycle, i.e. asserted one cycle after the pending bit is visible.
REQ-023 ACTIVE reads the lowest-indexed bit of (PENDING & MASK) as an unsigned index, or 'hFFFFFFFF if none is set.
REQ-024 Reads are registered: io_read_data and io_read_hit are valid the cycle after io_read_en.
REQ-025 io_read_hit is 0 in every cycle not following a mapped read; io_read_data holds its last value while io_read_hit is 0.
REQ-026 Register bits at and above NUM_SOURCES read as 0 and ignore writes.
REQ-027 A MODE change takes effect the next cycle; switching level->edge does not itself create an edge.
REQ-028 A read and a write asserted in the same cycle are both performed; the read returns the pre-write value.

Reset
REQ-029 While reset is low, the following are zero: PENDING, MASK, synchronizer and edge history, interrupt_req, io_read_hit and io_read_data; MODE is all ones (edge).
REQ-030 Assertion of reset mid-operation clears state immediately (asynchronously); a read in flight is dropped and no io_read_hit is produced.

Structure
REQ-031 The register offset constants and the ACTIVE empty code 'hFFFFFFFF reside in defines.sv alongside the existing IO definitions.
REQ-032 The two-flop synchronizer is a separate sub-module, synchronizer, parameterized by width and instantiated once at NUM_SOURCES bits.
REQ-033 A competent implementation is 120-400 lines of RTL, including the priority encoder for ACTIVE.

Verification
REQ-034 Reset state: release reset, read MASK, MODE and PENDING -> 0, 'h0000FFFF and 0 respectively; interrupt_req stays 0.
REQ-035 Edge path: MASK='h1, source0 rises at cycle 10 -> PENDING='h1 at cycle 13, interrupt_req=1 at cycle 14, ACTIVE=0; W1C 'h1 -> interrupt_req=0 two cycles later.
REQ-036 Set priority: a source3 edge lands in the same cycle as a W1C of 'h8 -> PENDING bit3 remains 1.
REQ-037 Level mode: MODE='h0, MASK='h4, source2 held high -> W1C 'h4 has no effect; source2 drops -> PENDING=0 three cycles later and interrupt_req=0 one cycle after that.
REQ-038 Priority and SET: SET write of 'h30 with MASK='h20 -> ACTIVE=5; with MASK=0 -> ACTIVE='hFFFFFFFF and interrupt_req=0.
REQ-039 Decode: read of BASE_ADDRESS+'h14 or BASE_ADDRESS+'h2 -> io_read_hit=0 and no state change; drive reset low during a read -> no io_read_hit is produced.

Source files
------------

// File: rtl/io_interrupt_controller_pkg.sv
// Shared types, register map and helpers for the IO interrupt controller.
//   scalar_t          : 32-bit IO data/address word
//   REG_*             : register word offsets from the block base address
//   ACTIVE_NONE       : ACTIVE read value when no enabled interrupt is pending
//   src_mask()        : ones in the low n bits, used to drop unimplemented bits
//   lowest_set_index(): priority encoder behind the ACTIVE register
package io_interrupt_controller_pkg;

  typedef logic [31:0] scalar_t;

  localparam int unsigned SCALAR_W = 32;

  localparam scalar_t REG_PENDING = 32'h0000_0000;
  localparam scalar_t REG_MASK    = 32'h0000_0004;
  localparam scalar_t REG_MODE    = 32'h0000_0008;
  localparam scalar_t REG_ACTIVE  = 32'h0000_000C;
  localparam scalar_t REG_SET     = 32'h0000_0010;

  localparam scalar_t ACTIVE_NONE = 32'hFFFF_FFFF;

  // Low n bits set; bits at and above n stay zero.
  function automatic scalar_t src_mask(input int unsigned n);
    scalar_t m;
    m = '0;
    for (int unsigned i = 0; i < SCALAR_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Index of the lowest set bit, or ACTIVE_NONE when the vector is empty.
  // Scanning downward lets the lowest index win the last assignment.
  function automatic scalar_t lowest_set_index(input scalar_t v);
    scalar_t idx;
    idx = ACTIVE_NONE;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/io_interrupt_controller_synchronizer.sv
// Two-flop synchronizer for asynchronous input lines.
//   clk, rst_n : clock, asynchronous active-low reset (clears both stages)
//   async_i    : asynchronous inputs
//   sync_o     : inputs delayed by two clock edges, safe to use in clk domain
module synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/io_interrupt_controller.sv
// Memory-mapped interrupt controller on the processor IO bus.
// Captures NUM_SOURCES asynchronous interrupt lines (edge or level per source),
// exposes PENDING/MASK/MODE/ACTIVE/SET registers and raises interrupt_req.
//   clk, reset         : clock, asynchronous active-low reset
//   interrupt_sources  : asynchronous device interrupt lines
//   io_write_en/io_read_en, io_address, io_write_data : IO bus request
//   io_read_data, io_read_hit : registered read response
//   interrupt_req      : registered request, |(PENDING & MASK) of last cycle
module io_interrupt_controller
  import io_interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_SOURCES  = 16,
  parameter scalar_t     BASE_ADDRESS = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] interrupt_sources,
  input  logic                   io_write_en,
  input  logic                   io_read_en,
  input  scalar_t                io_address,
  input  scalar_t                io_write_data,
  output scalar_t                io_read_data,
  output logic                   io_read_hit,
  output logic                   interrupt_req
);

  // Registers are held 32 bits wide; bits at and above NUM_SOURCES are tied
  // to zero through SRC_MASK and fold away as constant flops.
  localparam scalar_t SRC_MASK = src_mask(NUM_SOURCES);

  logic [NUM_SOURCES-1:0] sync_w;
  scalar_t sync_s;
  scalar_t edge_s;
  scalar_t w1c_s;
  scalar_t set_s;
  scalar_t offset_s;
  scalar_t active_s;
  scalar_t rdata_s;
  logic    addr_hit_s;

  scalar_t hist_q,      hist_d;
  scalar_t pending_q,   pending_d;
  scalar_t mask_q,      mask_d;
  scalar_t mode_q,      mode_d;
  scalar_t read_data_q, read_data_d;
  logic    read_hit_q,  read_hit_d;
  logic    irq_q,       irq_d;

  synchronizer #(
    .WIDTH (NUM_SOURCES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (reset),
    .async_i (interrupt_sources),
    .sync_o  (sync_w)
  );

  assign sync_s = 32'(sync_w);

  // Address decode: word-aligned offsets 0x0..0x10 from the base only.
  // Addresses below the base wrap to large offsets and miss.
  always_comb begin
    offset_s   = io_address - BASE_ADDRESS;
    addr_hit_s = (offset_s <= REG_SET) && (offset_s[1:0] == 2'b00);
  end

  // Register writes, capture and interrupt request next-state.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    w1c_s  = '0;
    set_s  = '0;
    if (io_write_en && addr_hit_s) begin
      case (offset_s)
        REG_PENDING: w1c_s  = io_write_data & SRC_MASK;
        REG_MASK:    mask_d = io_write_data & SRC_MASK;
        REG_MODE:    mode_d = io_write_data & SRC_MASK;
        REG_SET:     set_s  = io_write_data & SRC_MASK;
        default:     ;
      endcase
    end

    // History tracks the line in every mode, so a level->edge switch on a
    // line that is already high sees no rising edge.
    hist_d = sync_s;
    edge_s = sync_s & ~hist_q;

    // Edge bits: set events override a same-cycle W1C. Level bits follow
    // the synchronized line and ignore W1C/SET.
    pending_d = (mode_q & ((pending_q & ~w1c_s) | edge_s | set_s))
              | (~mode_q & sync_s);

    irq_d = |(pending_q & mask_q);
  end

  assign active_s = lowest_set_index(pending_q & mask_q);

  // Read path samples pre-write state; data holds between hits.
  always_comb begin
    case (offset_s)
      REG_PENDING: rdata_s = pending_q;
      REG_MASK:    rdata_s = mask_q;
      REG_MODE:    rdata_s = mode_q;
      REG_ACTIVE:  rdata_s = active_s;
      default:     rdata_s = '0;
    endcase
    read_hit_d  = io_read_en && addr_hit_s;
    read_data_d = read_hit_d ? rdata_s : read_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q      <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      mode_q      <= SRC_MASK;
      read_data_q <= '0;
      read_hit_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      read_data_q <= read_data_d;
      read_hit_q  <= read_hit_d;
      irq_q       <= irq_d;
    end
  end

  assign io_read_data  = read_data_q;
  assign io_read_hit   = read_hit_q;
  assign interrupt_req = irq_q;

endmodule

// File: tb/tb_io_interrupt_controller.sv
// Directed self-checking bench for io_interrupt_controller (default params).
module tb_io_interrupt_controller;
  import io_interrupt_controller_pkg::*;

  localparam scalar_t BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] src = '0;
  logic        io_write_en = 1'b0;
  logic        io_read_en = 1'b0;
  scalar_t     io_address = '0;
  scalar_t     io_write_data = '0;
  scalar_t     io_read_data;
  logic        io_read_hit;
  logic        interrupt_req;

  int total = 0;
  int bad = 0;

  io_interrupt_controller #(
    .NUM_SOURCES  (16),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .interrupt_sources (src),
    .io_write_en       (io_write_en),
    .io_read_en        (io_read_en),
    .io_address        (io_address),
    .io_write_data     (io_write_data),
    .io_read_data      (io_read_data),
    .io_read_hit       (io_read_hit),
    .interrupt_req     (interrupt_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input scalar_t got, input scalar_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input scalar_t off, input scalar_t data);
    io_write_en   = 1'b1;
    io_address    = BASE + off;
    io_write_data = data;
    tick();
    io_write_en = 1'b0;
  endtask

  task automatic rd(input string tag, input scalar_t off, input scalar_t exp);
    io_read_en = 1'b1;
    io_address = BASE + off;
    tick();
    io_read_en = 1'b0;
    check({tag, "_hit"}, 32'(io_read_hit), 32'h1);
    check(tag, io_read_data, exp);
  endtask

  task automatic rd_miss(input string tag, input scalar_t addr, input scalar_t hold);
    io_read_en = 1'b1;
    io_address = addr;
    tick();
    io_read_en = 1'b0;
    check({tag, "_hit"}, 32'(io_read_hit), 32'h0);
    check({tag, "_hold"}, io_read_data, hold);
  endtask

  initial begin
    // Reset values while held in reset, then after release.
    repeat (3) tick();
    check("rst_irq", 32'(interrupt_req), 32'h0);
    check("rst_hit", 32'(io_read_hit), 32'h0);
    check("rst_data", io_read_data, 32'h0);
    reset = 1'b1;
    tick();
    rd("rst_mask", REG_MASK, 32'h0);
    rd("rst_mode", REG_MODE, 32'h0000_FFFF);
    rd("rst_pend", REG_PENDING, 32'h0);
    check("rst_irq2", 32'(interrupt_req), 32'h0);

    // Edge path latency: PENDING three edges after the input, irq one later.
    wr(REG_MASK, 32'h1);
    src[0] = 1'b1;
    tick();
    tick();
    rd("edge_pend_early", REG_PENDING, 32'h0);
    check("edge_irq_early", 32'(interrupt_req), 32'h0);
    rd("edge_pend", REG_PENDING, 32'h1);
    check("edge_irq", 32'(interrupt_req), 32'h1);
    rd("edge_active", REG_ACTIVE, 32'h0);
    wr(REG_PENDING, 32'h1);
    check("w1c_irq_lag", 32'(interrupt_req), 32'h1);
    tick();
    check("w1c_irq_clr", 32'(interrupt_req), 32'h0);

    // Source3 edge captured in the same cycle as a W1C of bit3.
    src[3] = 1'b1;
    tick();
    tick();
    wr(REG_PENDING, 32'h8);
    rd("setprio_pend", REG_PENDING, 32'h8);
    wr(REG_PENDING, 32'h8);
    rd("held_no_edge", REG_PENDING, 32'h0);
    src = '0;
    repeat (4) tick();

    // Level mode: W1C ignored, PENDING follows the line.
    wr(REG_MODE, 32'h0);
    wr(REG_MASK, 32'h4);
    src[2] = 1'b1;
    repeat (4) tick();
    rd("lvl_pend", REG_PENDING, 32'h4);
    wr(REG_PENDING, 32'h4);
    rd("lvl_w1c_none", REG_PENDING, 32'h4);
    check("lvl_irq", 32'(interrupt_req), 32'h1);
    src[2] = 1'b0;
    tick();
    tick();
    rd("lvl_drop_early", REG_PENDING, 32'h4);
    check("lvl_irq_early", 32'(interrupt_req), 32'h1);
    rd("lvl_drop", REG_PENDING, 32'h0);
    check("lvl_irq_drop", 32'(interrupt_req), 32'h0);

    // Level->edge switch with the line high retains the bit but adds no edge.
    src[2] = 1'b1;
    repeat (4) tick();
    wr(REG_MODE, 32'h0000_FFFF);
    rd("sw_keep", REG_PENDING, 32'h4);
    wr(REG_PENDING, 32'h4);
    tick();
    tick();
    rd("sw_no_edge", REG_PENDING, 32'h0);
    src = '0;
    repeat (4) tick();

    // SET write and ACTIVE priority encoding.
    wr(REG_MASK, 32'h20);
    wr(REG_SET, 32'h30);
    rd("set_active", REG_ACTIVE, 32'h5);
    check("set_irq", 32'(interrupt_req), 32'h1);
    wr(REG_MASK, 32'h0);
    rd("none_active", REG_ACTIVE, 32'hFFFF_FFFF);
    check("none_irq", 32'(interrupt_req), 32'h0);
    rd("unmasked_pend", REG_PENDING, 32'h30);

    // Decode misses on reads and writes.
    rd_miss("miss_14", BASE + 32'h14, 32'h30);
    rd_miss("miss_02", BASE + 32'h2, 32'h30);
    wr(32'h6, 32'h0000_FFFF);
    wr(32'h14, 32'h0000_00FF);
    rd("miss_mask", REG_MASK, 32'h0);
    rd("miss_pend", REG_PENDING, 32'h30);
    wr(REG_MASK, 32'hFFFF_FFFF);
    rd("mask_width", REG_MASK, 32'h0000_FFFF);

    // Simultaneous read and write return the pre-write value.
    io_read_en    = 1'b1;
    io_write_en   = 1'b1;
    io_address    = BASE + REG_MASK;
    io_write_data = 32'h5;
    tick();
    io_read_en  = 1'b0;
    io_write_en = 1'b0;
    check("rw_hit", 32'(io_read_hit), 32'h1);
    check("rw_old", io_read_data, 32'h0000_FFFF);
    rd("rw_new", REG_MASK, 32'h5);

    // Reset asserted during a read drops the response and clears state.
    wr(REG_MASK, 32'h10);
    tick();
    check("pre_rst_irq", 32'(interrupt_req), 32'h1);
    io_read_en = 1'b1;
    io_address = BASE + REG_MASK;
    reset      = 1'b0;
    #1;
    check("async_irq", 32'(interrupt_req), 32'h0);
    check("async_data", io_read_data, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_hit", 32'(io_read_hit), 32'h0);
    io_read_en = 1'b0;
    reset      = 1'b1;
    tick();
    rd("midrst_pend", REG_PENDING, 32'h0);
    rd("midrst_mask", REG_MASK, 32'h0);
    rd("midrst_mode", REG_MODE, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
